// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic operand path.
// Contents:
//   feeder_state_e - load/feed sequencing states of the operand feeder
//   max2           - larger of two integers
//   clog2_min1     - index width for n entries, never less than one bit
//   beats          - wavefront length k + max(h, w) - 1
package systolic_pkg;

    typedef enum logic [1:0] {
        LOAD_A = 2'd0,
        LOAD_B = 2'd1,
        FEED   = 2'd2,
        DONE   = 2'd3
    } feeder_state_e;

    function automatic int max2(input int a, input int b);
        if (a > b) begin
            return a;
        end else begin
            return b;
        end
    endfunction

    function automatic int clog2_min1(input int n);
        if (n > 1) begin
            return $clog2(n);
        end else begin
            return 1;
        end
    endfunction

    function automatic int beats(input int k, input int h, input int w);
        return k + max2(h, w) - 1;
    endfunction

endpackage

// File: rtl/operand_buffer.sv
// Operand register file: width_p-wide entries laid out row-major as
// rows_p x cols_p, written one entry per cycle by linear index and read
// combinationally by (row, col) on rd_ports_p independent ports.
// A read that hits the entry being written this cycle returns the incoming
// data, so a consumer may use the final entry in the same cycle it arrives.
// Ports:
//   i_clk, i_rst       clock, asynchronous active-high reset (clears all entries)
//   i_wr_en            write strobe
//   i_wr_idx           linear write index (row * cols_p + col)
//   i_wr_data          write data
//   i_rd_row/i_rd_col  per-port read coordinates
//   o_rd_data          per-port read data (0 for out-of-range coordinates)
module operand_buffer
    import systolic_pkg::*;
#(
    parameter int width_p    = 8,
    parameter int rows_p     = 2,
    parameter int cols_p     = 2,
    parameter int rd_ports_p = 2,
    parameter int idx_w_p    = 3,
    parameter int row_w_p    = clog2_min1(rows_p),
    parameter int col_w_p    = clog2_min1(cols_p)
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_wr_en,
    input  logic [idx_w_p-1:0] i_wr_idx,
    input  logic [width_p-1:0] i_wr_data,
    input  logic [row_w_p-1:0] i_rd_row  [rd_ports_p],
    input  logic [col_w_p-1:0] i_rd_col  [rd_ports_p],
    output logic [width_p-1:0] o_rd_data [rd_ports_p]
);

    localparam int DEPTH = rows_p * cols_p;
    localparam int AW    = clog2_min1(DEPTH);

    logic [width_p-1:0] r_mem [DEPTH];
    logic [AW-1:0]      w_wr_addr;

    assign w_wr_addr = AW'(i_wr_idx);

    // Entry storage: cleared on reset, one linear-index write per cycle.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= {width_p{1'b0}};
            end
        end else if (i_wr_en && (int'(i_wr_idx) < DEPTH)) begin
            r_mem[w_wr_addr] <= i_wr_data;
        end else begin
            r_mem <= r_mem;
        end
    end

    // Read ports: write-forwarding first, then stored entry, then zero.
    always_comb begin
        int v_lin;
        v_lin = 0;
        for (int p = 0; p < rd_ports_p; p++) begin
            o_rd_data[p] = {width_p{1'b0}};
            v_lin = int'(i_rd_row[p]) * cols_p + int'(i_rd_col[p]);
            if (i_wr_en && (int'(i_wr_idx) == v_lin)) begin
                o_rd_data[p] = i_wr_data;
            end else if (v_lin < DEPTH) begin
                o_rd_data[p] = r_mem[AW'(v_lin)];
            end else begin
                o_rd_data[p] = {width_p{1'b0}};
            end
        end
    end

endmodule

// File: rtl/matrix_skew_feeder.sv
// Operand loader/skewer feeding a systolic array.
// Takes A (height x k) then B (k x width) row-major as a valid/ready byte
// stream, then replays them as diagonal wavefronts: row r of A delayed r beats,
// column c of B delayed c beats.
// Ports:
//   clk_i, reset_i  clock, asynchronous active-high reset
//   valid_i/data_i  upstream byte stream;  ready_o  feeder accepts a byte
//   en_i            downstream advance; low freezes the wavefront
//   a_o/a_v_o       per-row operand and valid (row r at [r*width_p +: width_p])
//   b_o/b_v_o       per-column operand and valid
//   busy_o          high in FEED and DONE;  done_o  one-cycle end pulse
// All outputs are registers loaded from the next state, so they line up with
// the state the FSM is in during the cycle they are visible.
module matrix_skew_feeder
    import systolic_pkg::*;
#(
    parameter int width_p        = 8,
    parameter int array_width_p  = 2,
    parameter int array_height_p = 2,
    parameter int k_p            = 2
) (
    input  logic                                clk_i,
    input  logic                                reset_i,
    input  logic                                valid_i,
    input  logic [width_p-1:0]                  data_i,
    output logic                                ready_o,
    input  logic                                en_i,
    output logic [array_height_p*width_p-1:0]   a_o,
    output logic [array_height_p-1:0]           a_v_o,
    output logic [array_width_p*width_p-1:0]    b_o,
    output logic [array_width_p-1:0]            b_v_o,
    output logic                                busy_o,
    output logic                                done_o
);

    localparam int H   = array_height_p;
    localparam int W   = array_width_p;
    localparam int K   = k_p;
    localparam int A_N = H * K;
    localparam int B_N = K * W;
    localparam int IW  = $clog2(max2(A_N, B_N) + 1);
    localparam int T   = beats(K, H, W);
    localparam int TW  = $clog2(T + 1);
    localparam int ARW = clog2_min1(H);
    localparam int ACW = clog2_min1(K);
    localparam int BRW = clog2_min1(K);
    localparam int BCW = clog2_min1(W);

    feeder_state_e          r_state, w_state_nxt;
    logic [IW-1:0]          r_idx, w_idx_nxt;
    logic [TW-1:0]          r_t, w_t_nxt;
    logic                   w_accept, w_a_wr, w_b_wr;

    logic [ARW-1:0]         w_a_row [H];
    logic [ACW-1:0]         w_a_col [H];
    logic [width_p-1:0]     w_a_rd  [H];
    logic [H-1:0]           w_a_hit;
    logic [BRW-1:0]         w_b_row [W];
    logic [BCW-1:0]         w_b_col [W];
    logic [width_p-1:0]     w_b_rd  [W];
    logic [W-1:0]           w_b_hit;

    logic [H*width_p-1:0]   r_a, w_a_nxt;
    logic [H-1:0]           r_a_v, w_a_v_nxt;
    logic [W*width_p-1:0]   r_b, w_b_nxt;
    logic [W-1:0]           r_b_v, w_b_v_nxt;
    logic                   r_busy, w_busy_nxt;
    logic                   r_done, w_done_nxt;
    logic                   r_ready, w_ready_nxt;

    assign w_accept = valid_i & r_ready;

    operand_buffer #(
        .width_p    (width_p),
        .rows_p     (H),
        .cols_p     (K),
        .rd_ports_p (H),
        .idx_w_p    (IW),
        .row_w_p    (ARW),
        .col_w_p    (ACW)
    ) u_a_buf (
        .i_clk      (clk_i),
        .i_rst      (reset_i),
        .i_wr_en    (w_a_wr),
        .i_wr_idx   (r_idx),
        .i_wr_data  (data_i),
        .i_rd_row   (w_a_row),
        .i_rd_col   (w_a_col),
        .o_rd_data  (w_a_rd)
    );

    operand_buffer #(
        .width_p    (width_p),
        .rows_p     (K),
        .cols_p     (W),
        .rd_ports_p (W),
        .idx_w_p    (IW),
        .row_w_p    (BRW),
        .col_w_p    (BCW)
    ) u_b_buf (
        .i_clk      (clk_i),
        .i_rst      (reset_i),
        .i_wr_en    (w_b_wr),
        .i_wr_idx   (r_idx),
        .i_wr_data  (data_i),
        .i_rd_row   (w_b_row),
        .i_rd_col   (w_b_col),
        .o_rd_data  (w_b_rd)
    );

    // Next-state, load index and beat counter; buffer write strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_t_nxt     = r_t;
        w_a_wr      = 1'b0;
        w_b_wr      = 1'b0;
        case (r_state)
            LOAD_A: begin
                if (w_accept) begin
                    w_a_wr = 1'b1;
                    if (r_idx == IW'(A_N - 1)) begin
                        w_state_nxt = LOAD_B;
                        w_idx_nxt   = {IW{1'b0}};
                    end else begin
                        w_idx_nxt = r_idx + IW'(1);
                    end
                end else begin
                    w_a_wr = 1'b0;
                end
            end
            LOAD_B: begin
                if (w_accept) begin
                    w_b_wr = 1'b1;
                    if (r_idx == IW'(B_N - 1)) begin
                        w_state_nxt = FEED;
                        w_idx_nxt   = {IW{1'b0}};
                        w_t_nxt     = {TW{1'b0}};
                    end else begin
                        w_idx_nxt = r_idx + IW'(1);
                    end
                end else begin
                    w_b_wr = 1'b0;
                end
            end
            FEED: begin
                if (en_i) begin
                    if (r_t == TW'(T - 1)) begin
                        w_state_nxt = DONE;
                        w_t_nxt     = {TW{1'b0}};
                    end else begin
                        w_t_nxt = r_t + TW'(1);
                    end
                end else begin
                    w_t_nxt = r_t;
                end
            end
            DONE: begin
                w_state_nxt = LOAD_A;
                w_idx_nxt   = {IW{1'b0}};
            end
            default: begin
                w_state_nxt = LOAD_A;
                w_idx_nxt   = {IW{1'b0}};
                w_t_nxt     = {TW{1'b0}};
            end
        endcase
    end

    // Skew addressing for the beat that will be visible next cycle: row r
    // reads A[r][t-r], column c reads B[t-c][c], when 0 <= t-r/t-c < k.
    always_comb begin
        int v_d;
        v_d = 0;
        for (int r = 0; r < H; r++) begin
            v_d        = int'(w_t_nxt) - r;
            w_a_hit[r] = (v_d >= 0) && (v_d < K);
            w_a_row[r] = ARW'(r);
            if (w_a_hit[r]) begin
                w_a_col[r] = ACW'(v_d);
            end else begin
                w_a_col[r] = {ACW{1'b0}};
            end
        end
        for (int c = 0; c < W; c++) begin
            v_d        = int'(w_t_nxt) - c;
            w_b_hit[c] = (v_d >= 0) && (v_d < K);
            w_b_col[c] = BCW'(c);
            if (w_b_hit[c]) begin
                w_b_row[c] = BRW'(v_d);
            end else begin
                w_b_row[c] = {BRW{1'b0}};
            end
        end
    end

    // Output values for the next state; operands are zero unless feeding.
    always_comb begin
        w_a_nxt     = {(H*width_p){1'b0}};
        w_a_v_nxt   = {H{1'b0}};
        w_b_nxt     = {(W*width_p){1'b0}};
        w_b_v_nxt   = {W{1'b0}};
        w_ready_nxt = (w_state_nxt == LOAD_A) || (w_state_nxt == LOAD_B);
        w_busy_nxt  = (w_state_nxt == FEED) || (w_state_nxt == DONE);
        w_done_nxt  = (w_state_nxt == DONE);
        if (w_state_nxt == FEED) begin
            for (int r = 0; r < H; r++) begin
                if (w_a_hit[r]) begin
                    w_a_v_nxt[r]                  = 1'b1;
                    w_a_nxt[r*width_p +: width_p] = w_a_rd[r];
                end else begin
                    w_a_v_nxt[r]                  = 1'b0;
                    w_a_nxt[r*width_p +: width_p] = {width_p{1'b0}};
                end
            end
            for (int c = 0; c < W; c++) begin
                if (w_b_hit[c]) begin
                    w_b_v_nxt[c]                  = 1'b1;
                    w_b_nxt[c*width_p +: width_p] = w_b_rd[c];
                end else begin
                    w_b_v_nxt[c]                  = 1'b0;
                    w_b_nxt[c*width_p +: width_p] = {width_p{1'b0}};
                end
            end
        end else begin
            w_a_v_nxt = {H{1'b0}};
            w_b_v_nxt = {W{1'b0}};
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state <= LOAD_A;
            r_idx   <= {IW{1'b0}};
            r_t     <= {TW{1'b0}};
            r_a     <= {(H*width_p){1'b0}};
            r_a_v   <= {H{1'b0}};
            r_b     <= {(W*width_p){1'b0}};
            r_b_v   <= {W{1'b0}};
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_ready <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_t     <= w_t_nxt;
            r_a     <= w_a_nxt;
            r_a_v   <= w_a_v_nxt;
            r_b     <= w_b_nxt;
            r_b_v   <= w_b_v_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_ready <= w_ready_nxt;
        end
    end

    assign a_o     = r_a;
    assign a_v_o   = r_a_v;
    assign b_o     = r_b;
    assign b_v_o   = r_b_v;
    assign busy_o  = r_busy;
    assign done_o  = r_done;
    assign ready_o = r_ready;

endmodule

// File: tb/tb_matrix_skew_feeder.sv
// Bench for matrix_skew_feeder: default 2x2x2 instance plus a 3x2x1 instance.
// Expected wavefronts come from the A/B matrices recorded while loading.
module tb_matrix_skew_feeder;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid0, en0, valid1, en1;
    logic [7:0]  data0, data1;
    logic        ready0, busy0, done0, ready1, busy1, done1;
    logic [15:0] a0, b0, b1;
    logic [23:0] a1;
    logic [1:0]  av0, bv0, bv1;
    logic [2:0]  av1;

    int checks = 0;
    int errors = 0;
    int ma [4][4];
    int mb [4][4];
    bit sel = 1'b0;

    logic [63:0] obs_a, obs_av, obs_b, obs_bv;
    logic        obs_ready, obs_busy, obs_done;

    always #5 clk = ~clk;

    matrix_skew_feeder #(.width_p(8), .array_width_p(2), .array_height_p(2), .k_p(2)) dut0 (
        .clk_i(clk), .reset_i(rst), .valid_i(valid0), .data_i(data0), .ready_o(ready0),
        .en_i(en0), .a_o(a0), .a_v_o(av0), .b_o(b0), .b_v_o(bv0),
        .busy_o(busy0), .done_o(done0));

    matrix_skew_feeder #(.width_p(8), .array_width_p(2), .array_height_p(3), .k_p(1)) dut1 (
        .clk_i(clk), .reset_i(rst), .valid_i(valid1), .data_i(data1), .ready_o(ready1),
        .en_i(en1), .a_o(a1), .a_v_o(av1), .b_o(b1), .b_v_o(bv1),
        .busy_o(busy1), .done_o(done1));

    assign obs_a     = sel ? {40'd0, a1}  : {48'd0, a0};
    assign obs_av    = sel ? {61'd0, av1} : {62'd0, av0};
    assign obs_b     = sel ? {48'd0, b1}  : {48'd0, b0};
    assign obs_bv    = sel ? {62'd0, bv1} : {62'd0, bv0};
    assign obs_ready = sel ? ready1 : ready0;
    assign obs_busy  = sel ? busy1  : busy0;
    assign obs_done  = sel ? done1  : done0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [7:0] d);
        if (sel) begin valid1 = v; data1 = d; end
        else     begin valid0 = v; data0 = d; end
    endtask

    task automatic drive_en(input logic e);
        if (sel) en1 = e; else en0 = e;
    endtask

    // Expected beat t: row r carries A[r][t-r] when 0 <= t-r < k.
    function automatic logic [63:0] exp_a(input int t, input int h, input int k);
        logic [63:0] v;
        int          e;
        v = 64'd0;
        for (int r = 0; r < h; r++) begin
            if (t - r >= 0 && t - r < k) begin
                e = ma[r][t-r];
                v[r*8 +: 8] = e[7:0];
            end
        end
        return v;
    endfunction

    function automatic logic [63:0] exp_av(input int t, input int h, input int k);
        logic [63:0] v;
        v = 64'd0;
        for (int r = 0; r < h; r++) if (t - r >= 0 && t - r < k) v[r] = 1'b1;
        return v;
    endfunction

    // Expected beat t: column c carries B[t-c][c] when 0 <= t-c < k.
    function automatic logic [63:0] exp_b(input int t, input int w, input int k);
        logic [63:0] v;
        int          e;
        v = 64'd0;
        for (int c = 0; c < w; c++) begin
            if (t - c >= 0 && t - c < k) begin
                e = mb[t-c][c];
                v[c*8 +: 8] = e[7:0];
            end
        end
        return v;
    endfunction

    function automatic logic [63:0] exp_bv(input int t, input int w, input int k);
        logic [63:0] v;
        v = 64'd0;
        for (int c = 0; c < w; c++) if (t - c >= 0 && t - c < k) v[c] = 1'b1;
        return v;
    endfunction

    task automatic check_idle(input string tag);
        check({tag, "_a"},     obs_a,     64'd0);
        check({tag, "_av"},    obs_av,    64'd0);
        check({tag, "_b"},     obs_b,     64'd0);
        check({tag, "_bv"},    obs_bv,    64'd0);
        check({tag, "_ready"}, obs_ready, 64'd1);
        check({tag, "_busy"},  obs_busy,  64'd0);
        check({tag, "_done"},  obs_done,  64'd0);
    endtask

    // Load A then B; called and returning at a negedge.
    task automatic load(input int h, input int w, input int k,
                        input bit rnd, input int base, input bit gaps);
        int         na, nb;
        logic [7:0] bval;
        na = h * k;
        nb = k * w;
        for (int i = 0; i < na + nb; i++) begin
            bval = rnd ? 8'($urandom_range(0, 255)) : 8'(base + i);
            if (i < na) ma[i / k][i % k] = int'(bval);
            else        mb[(i - na) / w][(i - na) % w] = int'(bval);
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    drive(1'b0, 8'($urandom_range(0, 255)));
                    @(negedge clk);
                end
            end
            check("ready_load", obs_ready, 64'd1);
            drive(1'b1, bval);
            @(negedge clk);
        end
        check("ready_drop", obs_ready, 64'd0);
        drive(1'b0, 8'd0);
    endtask

    // Check the wavefront beat by beat, then DONE and the return to LOAD_A.
    task automatic run_wave(input int h, input int w, input int k,
                            input int stall_at, input int stall_len,
                            input bit hold, input int reset_at);
        int T, bt, st;
        bit aborted;
        T = k + ((h > w) ? h : w) - 1;
        bt = 0;
        st = 0;
        aborted = 1'b0;
        if (hold) drive(1'b1, 8'hEE);
        while (bt < T && !aborted) begin
            check("beat_a",     obs_a,     exp_a(bt, h, k));
            check("beat_av",    obs_av,    exp_av(bt, h, k));
            check("beat_b",     obs_b,     exp_b(bt, w, k));
            check("beat_bv",    obs_bv,    exp_bv(bt, w, k));
            check("beat_busy",  obs_busy,  64'd1);
            check("beat_done",  obs_done,  64'd0);
            check("beat_ready", obs_ready, 64'd0);
            if (bt == reset_at) begin
                #1 rst = 1'b1;
                #1 check_idle("async_rst");
                #1 rst = 1'b0;
                drive(1'b0, 8'd0);
                drive_en(1'b1);
                aborted = 1'b1;
            end else begin
                if (bt == stall_at && st < stall_len) begin
                    drive_en(1'b0);
                    st++;
                end else begin
                    drive_en(1'b1);
                    bt++;
                end
                @(negedge clk);
            end
        end
        if (!aborted) begin
            check("done_pulse", obs_done,  64'd1);
            check("done_av",    obs_av,    64'd0);
            check("done_bv",    obs_bv,    64'd0);
            check("done_busy",  obs_busy,  64'd1);
            check("done_ready", obs_ready, 64'd0);
            @(negedge clk);
            check("post_done",  obs_done,  64'd0);
            check("post_busy",  obs_busy,  64'd0);
            check("post_ready", obs_ready, 64'd1);
            check("post_av",    obs_av,    64'd0);
        end
    endtask

    initial begin
        rst = 1'b1;
        valid0 = 1'b0; data0 = 8'd0; en0 = 1'b1;
        valid1 = 1'b0; data1 = 8'd0; en1 = 1'b1;
        #2;
        sel = 1'b0; #1 check_idle("reset0");
        sel = 1'b1; #1 check_idle("reset1");
        sel = 1'b0;
        #4 rst = 1'b0;
        @(negedge clk);

        // 1: fixed 1..8 back-to-back
        load(2, 2, 2, 1'b0, 1, 1'b0);
        run_wave(2, 2, 2, -1, 0, 1'b0, -1);
        // 2: random data with valid gaps
        load(2, 2, 2, 1'b1, 0, 1'b1);
        run_wave(2, 2, 2, -1, 0, 1'b0, -1);
        // 3: three-cycle stall at beat 1
        load(2, 2, 2, 1'b0, 1, 1'b0);
        run_wave(2, 2, 2, 1, 3, 1'b0, -1);
        // 4: valid held through FEED/DONE, then a second load of 9..16
        load(2, 2, 2, 1'b0, 1, 1'b0);
        run_wave(2, 2, 2, -1, 0, 1'b1, -1);
        load(2, 2, 2, 1'b0, 9, 1'b0);
        run_wave(2, 2, 2, -1, 0, 1'b0, -1);
        // 5: async reset mid-beat1, then a fresh load
        load(2, 2, 2, 1'b1, 0, 1'b0);
        run_wave(2, 2, 2, -1, 0, 1'b0, 1);
        load(2, 2, 2, 1'b1, 0, 1'b1);
        run_wave(2, 2, 2, 2, 2, 1'b0, -1);
        // 6: H=3, W=2, k=1
        sel = 1'b1;
        @(negedge clk);
        load(3, 2, 1, 1'b1, 0, 1'b0);
        run_wave(3, 2, 1, -1, 0, 1'b0, -1);
        load(3, 2, 1, 1'b1, 0, 1'b1);
        run_wave(3, 2, 1, 2, 2, 1'b1, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
